// File: rtl/instruction_fetch.sv
// PC + fetch stage feeding controlpath; a new word is valid one edge after the address is issued (1 instr / 2 cycles).
// No backpressure port: halt freezes the held word, and jump/increment are only honoured while a word is held.
module instruction_fetch #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  program_counter_increment,
    input  logic                  jump_enable,
    input  logic [15:0]           jump_target,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [15:0]           mem_data,
    output logic [15:0]           current_instruction,
    output logic                  instruction_valid,
    output logic [15:0]           program_counter
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] instr_q;
    logic        valid_q;
    logic        redirect;

    // Jump beats increment when both are requested in the same cycle.
    always_comb begin
        pc_d     = jump_enable ? jump_target : pc_q + 16'd1;
        redirect = (state_q == READY) && !halt
                   && (jump_enable || program_counter_increment);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    instr_q <= mem_data;
                    valid_q <= 1'b1;
                    state_q <= READY;
                end
                READY: begin
                    if (redirect) begin
                        pc_q    <= pc_d;
                        instr_q <= 16'h0000;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= START;
                    instr_q <= 16'h0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_address         = pc_q[ADDR_WIDTH-1:0];
    assign program_counter     = pc_q;
    assign current_instruction = instr_q;
    assign instruction_valid   = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed walk through the fetch scenarios, then random stimulus against a cycle-count reference model.
module tb_instruction_fetch;

    logic        clock;
    logic        resetn;
    logic        program_counter_increment;
    logic        jump_enable;
    logic [15:0] jump_target;
    logic        halt;
    logic [7:0]  mem_address;
    logic [15:0] mem_data;
    logic [15:0] current_instruction;
    logic        instruction_valid;
    logic [15:0] program_counter;

    logic [15:0] rom [256];
    assign mem_data = rom[mem_address];

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(16'h0000)) dut (
        .clock                     (clock),
        .resetn                    (resetn),
        .program_counter_increment (program_counter_increment),
        .jump_enable               (jump_enable),
        .jump_target               (jump_target),
        .halt                      (halt),
        .mem_address               (mem_address),
        .mem_data                  (mem_data),
        .current_instruction       (current_instruction),
        .instruction_valid         (instruction_valid),
        .program_counter           (program_counter)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: after reset a word arrives 2 edges later; after an accepted
    // jump/increment it arrives 1 edge later; in between, requests are ignored.
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic        m_valid = 1'b0;
    int          m_wait  = 2;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0; m_wait = 2;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_instr = rom[m_pc[7:0]];
                m_valid = 1'b1;
            end
        end else if (!halt && (jump_enable || program_counter_increment)) begin
            m_pc    = jump_enable ? jump_target : m_pc + 16'd1;
            m_instr = 16'h0000;
            m_valid = 1'b0;
            m_wait  = 1;
        end
    end

    always @(negedge clock) begin
        chk("model_pc",    {16'h0, program_counter},     {16'h0, m_pc});
        chk("model_addr",  {24'h0, mem_address},         {24'h0, m_pc[7:0]});
        chk("model_valid", {31'h0, instruction_valid},   {31'h0, m_valid});
        chk("model_instr", {16'h0, current_instruction}, {16'h0, m_instr});
    end

    task automatic idle_inputs();
        program_counter_increment = 1'b0;
        jump_enable = 1'b0;
        jump_target = 16'h0000;
        halt = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'h00] = 16'hE066;
        rom[8'h01] = 16'hE027;
        rom[8'h05] = 16'h1567;
        rom[8'h33] = 16'hBEEF;

        repeat (2) @(negedge clock);
        chk("rst_pc",    {16'h0, program_counter},     32'h0);
        chk("rst_valid", {31'h0, instruction_valid},   32'h0);
        chk("rst_instr", {16'h0, current_instruction}, 32'h0);
        resetn = 1'b1;
        @(negedge clock);
        chk("start_valid", {31'h0, instruction_valid}, 32'h0);
        @(negedge clock);
        chk("first_instr", {16'h0, current_instruction}, 32'hE066);
        chk("first_valid", {31'h0, instruction_valid},   32'h1);
        chk("first_pc",    {16'h0, program_counter},     32'h0);

        program_counter_increment = 1'b1;
        @(negedge clock);
        program_counter_increment = 1'b0;
        chk("inc_valid", {31'h0, instruction_valid},   32'h0);
        chk("inc_instr", {16'h0, current_instruction}, 32'h0);
        chk("inc_pc",    {16'h0, program_counter},     32'h1);
        @(negedge clock);
        chk("inc_word", {16'h0, current_instruction}, 32'hE027);
        chk("inc_vld",  {31'h0, instruction_valid},   32'h1);

        jump_enable = 1'b1; jump_target = 16'h0005; program_counter_increment = 1'b1;
        @(negedge clock);
        idle_inputs();
        chk("jmp_pc", {16'h0, program_counter}, 32'h5);
        @(negedge clock);
        chk("jmp_word", {16'h0, current_instruction}, 32'h1567);

        halt = 1'b1; program_counter_increment = 1'b1;
        repeat (10) begin
            @(negedge clock);
            chk("halt_pc",    {16'h0, program_counter},     32'h5);
            chk("halt_instr", {16'h0, current_instruction}, 32'h1567);
            chk("halt_valid", {31'h0, instruction_valid},   32'h1);
        end
        halt = 1'b0;
        @(negedge clock);
        program_counter_increment = 1'b0;
        chk("unhalt_pc", {16'h0, program_counter}, 32'h6);

        // halt raised while the read is in flight must not block capture
        halt = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("fhalt_valid", {31'h0, instruction_valid},   32'h1);
            chk("fhalt_instr", {16'h0, current_instruction}, {16'h0, rom[8'h06]});
        end
        halt = 1'b0;

        jump_enable = 1'b1; jump_target = 16'hFFFF;
        @(negedge clock);
        idle_inputs();
        chk("ffff_addr", {24'h0, mem_address}, 32'hFF);
        @(negedge clock);
        program_counter_increment = 1'b1;
        @(negedge clock);
        program_counter_increment = 1'b0;
        chk("wrap_pc",   {16'h0, program_counter}, 32'h0);
        chk("wrap_addr", {24'h0, mem_address},     32'h0);
        @(negedge clock);

        jump_enable = 1'b1; jump_target = 16'h0133;
        @(negedge clock);
        idle_inputs();
        chk("trunc_pc",   {16'h0, program_counter}, 32'h133);
        chk("trunc_addr", {24'h0, mem_address},     32'h33);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_pc",    {16'h0, program_counter},     32'h0);
        chk("midrst_valid", {31'h0, instruction_valid},   32'h0);
        chk("midrst_instr", {16'h0, current_instruction}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("midrst_hold", {16'h0, current_instruction}, 32'h0);
        @(negedge clock);
        chk("midrst_word", {16'h0, current_instruction}, 32'hE066);

        for (int c = 0; c < 3000; c++) begin
            program_counter_increment = ($urandom_range(1) == 1);
            jump_enable = ($urandom_range(3) == 0);
            halt        = ($urandom_range(3) == 0);
            jump_target = 16'($urandom);
            if ($urandom_range(199) == 0) begin
                #1 resetn = 1'b0;
                #2 resetn = 1'b1;
            end
            @(negedge clock);
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
